eco32f_wb_arbiter: RTL and testbench
====================================

# eco32f_wb_arbiter

Two-master to one-slave Wishbone B3 arbiter that shares the single external memory bus between the eco32f instruction fetch master (iwbm) and the load/store data master (dwbm). It sits between the core and the SoC interconnect. Grants are round-robin and held for a whole `cyc` tenure, so incrementing bursts and write cycles are never split. A watchdog returns a bus error to the owning master when the slave stops responding.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles an owner may hold `stb` high without any ack/err/rty before the arbiter aborts. A value of 0 disables the watchdog. The counter is 8 bits wide; legal range is 0..255.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `iwbm_adr_i`/`dwbm_adr_i`  in  32  master address.
- `iwbm_dat_i`/`dwbm_dat_i`  in  32  master write data.
- `iwbm_sel_i`/`dwbm_sel_i`  in  4  byte selects.
- `iwbm_cyc_i`, `iwbm_stb_i`, `iwbm_we_i` and the `dwbm_` equivalents  in  1 each  Wishbone controls.
- `iwbm_cti_i`/`dwbm_cti_i`  in  3  cycle type; `iwbm_bte_i`/`dwbm_bte_i`  in  2  burst type.
- `iwbm_ack_o`, `iwbm_err_o`, `iwbm_rty_o` and the `dwbm_` equivalents  out  1 each  responses to each master.
- `iwbm_dat_o`/`dwbm_dat_o`  out  32  read data.
- `wbm_adr_o`  out  32; `wbm_dat_o`  out  32; `wbm_sel_o`  out  4; `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each; `wbm_cti_o`  out  3; `wbm_bte_o`  out  2.
- `wbm_ack_i`, `wbm_err_i`, `wbm_rty_i`  in  1 each; `wbm_dat_i`  in  32.

## Operation
- Registered state machine with four states: IDLE, GNT_I, GNT_D, ABORT. The machine also holds a `last` bit (last owner) and an 8-bit watchdog counter `wd_cnt`.
- **IDLE.** All `wbm_*` outputs are 0 and all master ack/err/rty outputs are 0. Arbitration:
  - Only `dwbm_cyc_i` high → GNT_D.
  - Only `iwbm_cyc_i` high → GNT_I.
  - Both high → grant the master that is not `last`.
  - Neither high → stay in IDLE.
- **GNT_x.** All `wbm_*` outputs mirror master x combinationally.
  - `wbm_ack_i`, `wbm_err_i` and `wbm_rty_i` are routed only to master x; the other master sees 0.
  - `wbm_dat_i` is broadcast to both `*_dat_o` in every state.
  - `last` is set to x on entry.
  - When x drops `cyc` → IDLE. The grant is not revoked while x's `cyc` is high, including across `cti=010` bursts and back-to-back `stb` pulses.
- **Watchdog.**
  - `wd_cnt` clears on entry to a grant state, on any cycle with ack/err/rty, and whenever the owner's `stb` is 0.
  - Otherwise `wd_cnt` increments.
  - When `TIMEOUT_CYCLES`≠0 and `wd_cnt`==`TIMEOUT_CYCLES`-1 with no response that cycle: assert the owner's `err_o` combinationally for that one cycle, then go to ABORT.
- **ABORT.** `wbm_cyc_o`/`wbm_stb_o` are 0 and the owner's responses are 0. When the owner's `cyc` is 0 → IDLE. A late slave ack in ABORT is discarded.
- Simultaneous events:
  - If a slave response arrives in the same cycle the watchdog would fire, the response wins and no err is generated.
  - If the owner drops `cyc` in the same cycle the watchdog fires, the err is still driven and the next state is ABORT.

## Timing
- **Reset.** State IDLE, `last`=I (so the data master wins the first tie), `wd_cnt`=0. Every output is 0 while `rst`=0, regardless of `clk`.
- **Grant latency.** A `cyc` request first seen in IDLE at edge N is visible on `wbm_cyc_o` in cycle N+1. Slave responses pass through with zero added latency.
- **Release and turnaround.** If the owner drops `cyc` at cycle M, the state is IDLE at M+1 and a pending other master is granted at M+2. There is always at least one idle bus cycle between tenures.
- **Reset mid-burst.** `wbm_cyc_o` falls immediately and asynchronously. No ack reaches either master after reset assertion.

## Test plan
- **Single requester.** Data master issues a single read (`cyc`/`stb` at cycle 0, `adr`=0x1000_0040). Required: `wbm_cyc_o`=1 and `wbm_adr_o`=0x1000_0040 from cycle 1. A slave ack at cycle 3 appears on `dwbm_ack_o` in cycle 3 only, and `iwbm_ack_o` stays 0.
- **Tie after reset.** Both masters assert `cyc` at cycle 0. Required: data is granted first. After data drops `cyc`, instruction is granted 2 cycles later. A second tie then goes to data again (round-robin alternation).
- **Burst integrity.** Instruction master runs an 8-beat `cti=010` refill while data requests at beat 2. Required: all 8 acks go to instruction, and data is granted only after instruction drops `cyc`.
- **Watchdog.** Data master write with `TIMEOUT_CYCLES`=4 and a slave that never acks. Required: `dwbm_err_o` pulses for exactly one cycle 4 cycles after grant. `wbm_cyc_o`=0 the next cycle, then ABORT → IDLE after `dwbm_cyc_i` falls. A late ack is not forwarded.
- **Response beats watchdog.** Ack arrives in the same cycle as the watchdog limit. Required: ack is forwarded and no err is generated.
- **Asynchronous reset.** `rst` pulled low mid-burst between clock edges. Required: all outputs are 0 immediately. After release, a new request is granted normally with data priority.

Source files
------------

// File: rtl/eco32f_wb_arbiter.sv
// Two-master (instruction fetch, load/store) to one-slave Wishbone B3 arbiter.
// Round-robin grants held for a full cyc tenure, with a stall watchdog that errors the owner.
module eco32f_wb_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction fetch master
    input  logic [31:0] iwbm_adr_i,
    input  logic [31:0] iwbm_dat_i,
    input  logic [3:0]  iwbm_sel_i,
    input  logic        iwbm_cyc_i,
    input  logic        iwbm_stb_i,
    input  logic        iwbm_we_i,
    input  logic [2:0]  iwbm_cti_i,
    input  logic [1:0]  iwbm_bte_i,
    output logic        iwbm_ack_o,
    output logic        iwbm_err_o,
    output logic        iwbm_rty_o,
    output logic [31:0] iwbm_dat_o,
    // load/store master
    input  logic [31:0] dwbm_adr_i,
    input  logic [31:0] dwbm_dat_i,
    input  logic [3:0]  dwbm_sel_i,
    input  logic        dwbm_cyc_i,
    input  logic        dwbm_stb_i,
    input  logic        dwbm_we_i,
    input  logic [2:0]  dwbm_cti_i,
    input  logic [1:0]  dwbm_bte_i,
    output logic        dwbm_ack_o,
    output logic        dwbm_err_o,
    output logic        dwbm_rty_o,
    output logic [31:0] dwbm_dat_o,
    // shared slave port
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD,
        StAbort
    } state_e;

    localparam logic       WdEn    = (TIMEOUT_CYCLES != 0);
    localparam logic [7:0] WdLimit = 8'(TIMEOUT_CYCLES - 1);

    state_e     state_q, state_d;
    logic       last_q, last_d;      // 1: data master owned the bus last
    logic [7:0] wd_cnt_q, wd_cnt_d;

    logic granted;
    logic own_cyc;
    logic own_stb;
    logic resp;
    logic wd_fire;

    // last_q always names the current owner while not idle (it is loaded on grant entry)
    assign granted = (state_q == StGntI) || (state_q == StGntD);
    assign own_cyc = last_q ? dwbm_cyc_i : iwbm_cyc_i;
    assign own_stb = last_q ? dwbm_stb_i : iwbm_stb_i;
    assign resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign wd_fire = WdEn && granted && own_stb && !resp && (wd_cnt_q == WdLimit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            last_q   <= 1'b0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        wd_cnt_d = wd_cnt_q;
        unique case (state_q)
            StIdle: begin
                wd_cnt_d = '0;
                if (iwbm_cyc_i && dwbm_cyc_i) begin
                    last_d  = ~last_q;
                    state_d = last_q ? StGntI : StGntD;
                end else if (dwbm_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = StGntD;
                end else if (iwbm_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = StGntI;
                end
            end
            StGntI, StGntD: begin
                wd_cnt_d = (resp || !own_stb) ? 8'd0 : wd_cnt_q + 8'd1;
                // a firing watchdog wins over a simultaneous cyc release
                if (wd_fire) begin
                    state_d = StAbort;
                end else if (!own_cyc) begin
                    state_d = StIdle;
                end
            end
            StAbort: begin
                if (!own_cyc) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wbm_adr_o  = '0;
        wbm_dat_o  = '0;
        wbm_sel_o  = '0;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_cti_o  = '0;
        wbm_bte_o  = '0;
        iwbm_ack_o = 1'b0;
        iwbm_err_o = 1'b0;
        iwbm_rty_o = 1'b0;
        dwbm_ack_o = 1'b0;
        dwbm_err_o = 1'b0;
        dwbm_rty_o = 1'b0;
        // read data is broadcast, but must still read as zero while reset is held
        iwbm_dat_o = rst ? wbm_dat_i : '0;
        dwbm_dat_o = rst ? wbm_dat_i : '0;
        if (granted) begin
            wbm_adr_o  = last_q ? dwbm_adr_i : iwbm_adr_i;
            wbm_dat_o  = last_q ? dwbm_dat_i : iwbm_dat_i;
            wbm_sel_o  = last_q ? dwbm_sel_i : iwbm_sel_i;
            wbm_cyc_o  = own_cyc;
            wbm_stb_o  = own_stb;
            wbm_we_o   = last_q ? dwbm_we_i : iwbm_we_i;
            wbm_cti_o  = last_q ? dwbm_cti_i : iwbm_cti_i;
            wbm_bte_o  = last_q ? dwbm_bte_i : iwbm_bte_i;
            iwbm_ack_o = !last_q && wbm_ack_i;
            iwbm_err_o = !last_q && (wbm_err_i || wd_fire);
            iwbm_rty_o = !last_q && wbm_rty_i;
            dwbm_ack_o = last_q && wbm_ack_i;
            dwbm_err_o = last_q && (wbm_err_i || wd_fire);
            dwbm_rty_o = last_q && wbm_rty_i;
        end
    end

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Scoreboard bench for eco32f_wb_arbiter: a bus-ownership model predicts grants and
// responses; a negedge monitor matches them against what the DUT presents.
module tb_eco32f_wb_arbiter;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // index 0 = instruction master, 1 = data master
    logic [31:0] m_adr[2];
    logic [31:0] m_dat[2];
    logic [3:0]  m_sel[2];
    logic        m_cyc[2];
    logic        m_stb[2];
    logic        m_we[2];
    logic [2:0]  m_cti[2];
    logic [1:0]  m_bte[2];
    logic        s_ack, s_err, s_rty;
    logic [31:0] s_dat;

    logic        i_ack, i_err, i_rty, d_ack, d_err, d_rty;
    logic [31:0] i_dat, d_dat, w_adr, w_dat;
    logic [3:0]  w_sel;
    logic        w_cyc, w_stb, w_we;
    logic [2:0]  w_cti;
    logic [1:0]  w_bte;

    eco32f_wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .iwbm_adr_i(m_adr[0]), .iwbm_dat_i(m_dat[0]), .iwbm_sel_i(m_sel[0]),
        .iwbm_cyc_i(m_cyc[0]), .iwbm_stb_i(m_stb[0]), .iwbm_we_i(m_we[0]),
        .iwbm_cti_i(m_cti[0]), .iwbm_bte_i(m_bte[0]),
        .iwbm_ack_o(i_ack), .iwbm_err_o(i_err), .iwbm_rty_o(i_rty), .iwbm_dat_o(i_dat),
        .dwbm_adr_i(m_adr[1]), .dwbm_dat_i(m_dat[1]), .dwbm_sel_i(m_sel[1]),
        .dwbm_cyc_i(m_cyc[1]), .dwbm_stb_i(m_stb[1]), .dwbm_we_i(m_we[1]),
        .dwbm_cti_i(m_cti[1]), .dwbm_bte_i(m_bte[1]),
        .dwbm_ack_o(d_ack), .dwbm_err_o(d_err), .dwbm_rty_o(d_rty), .dwbm_dat_o(d_dat),
        .wbm_adr_o(w_adr), .wbm_dat_o(w_dat), .wbm_sel_o(w_sel), .wbm_cyc_o(w_cyc),
        .wbm_stb_o(w_stb), .wbm_we_o(w_we), .wbm_cti_o(w_cti), .wbm_bte_o(w_bte),
        .wbm_ack_i(s_ack), .wbm_err_i(s_err), .wbm_rty_i(s_rty), .wbm_dat_i(s_dat)
    );

    typedef struct { int cyc; int m; int kind; logic [31:0] dat; } rsp_t;
    typedef struct { int cyc; logic [31:0] adr; logic we; logic [3:0] sel; } gnt_t;
    rsp_t rsp_q[$];
    gnt_t gnt_q[$];

    int n_vec = 0;
    int n_miss = 0;
    int cyc_n = 0;

    // ownership model: who holds the bus, whether it is being aborted, stall length
    int owner = -1;
    bit aborting = 0;
    int last_m = 0;
    int quiet = 0;
    bit new_ten = 0;
    bit fire_now, resp_now;
    bit got_ack[2], got_err[2];

    // random master/slave state
    bit m_act[2];
    int m_left[2];
    bit m_burst[2];
    int stall = 0;
    logic prev_wcyc = 1'b0;

    task automatic model_reset();
        owner = -1; aborting = 0; last_m = 0; quiet = 0; new_ten = 0;
    endtask

    task automatic predict();
        rsp_t r;
        gnt_t g;
        fire_now = 0;
        resp_now = s_ack | s_err | s_rty;
        for (int m = 0; m < 2; m++) begin got_ack[m] = 0; got_err[m] = 0; end
        if (owner >= 0 && !aborting) begin
            if (new_ten && m_cyc[owner]) begin
                g.cyc = cyc_n; g.adr = m_adr[owner]; g.we = m_we[owner]; g.sel = m_sel[owner];
                gnt_q.push_back(g);
            end
            if (m_stb[owner] && !resp_now && quiet == TO - 1) begin
                fire_now = 1;
                r.cyc = cyc_n; r.m = owner; r.kind = 1; r.dat = s_dat;
                rsp_q.push_back(r);
                got_err[owner] = 1;
            end else if (resp_now) begin
                r.cyc = cyc_n; r.m = owner; r.kind = s_ack ? 0 : (s_err ? 1 : 2); r.dat = s_dat;
                rsp_q.push_back(r);
                got_ack[owner] = s_ack;
                got_err[owner] = s_err;
            end
        end
    endtask

    task automatic model_edge();
        new_ten = 0;
        if (owner < 0) begin
            if (m_cyc[0] || m_cyc[1]) begin
                owner = (m_cyc[0] && m_cyc[1]) ? 1 - last_m : (m_cyc[1] ? 1 : 0);
                last_m = owner; quiet = 0; new_ten = 1;
            end
        end else if (aborting) begin
            if (!m_cyc[owner]) begin owner = -1; aborting = 0; end
        end else if (fire_now) begin
            aborting = 1;
        end else if (!m_cyc[owner]) begin
            owner = -1;
        end else begin
            quiet = (resp_now || !m_stb[owner]) ? 0 : quiet + 1;
        end
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        #1;
        model_edge();
        cyc_n++;
    endtask

    task automatic req(int m, logic c, logic s, logic [31:0] a, logic w, logic [2:0] cti);
        m_cyc[m] = c; m_stb[m] = s; m_adr[m] = a; m_we[m] = w; m_cti[m] = cti;
        m_dat[m] = $urandom; m_sel[m] = 4'hf; m_bte[m] = 2'b00;
    endtask

    task automatic slv(logic a, logic e, logic r);
        s_ack = a; s_err = e; s_rty = r; s_dat = $urandom;
    endtask

    task automatic cycles(int n, logic a);
        for (int k = 0; k < n; k++) begin slv(a, 1'b0, 1'b0); step(); end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic check_zero(string name);
        logic [191:0] all;
        all = {i_ack, i_err, i_rty, d_ack, d_err, d_rty, i_dat, d_dat, w_adr, w_dat, w_sel,
               w_cyc, w_stb, w_we, w_cti, w_bte};
        n_vec++;
        if (all !== '0) begin
            n_miss++;
            $display("FAIL %s: outputs %h want all zero", name, all);
        end
    endtask

    task automatic check_rsp(int m, int k, logic v, logic [31:0] d);
        if (v) begin
            n_vec++;
            if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc_n) begin
                n_miss++;
                $display("FAIL unexpected_rsp: got master %0d kind %0d at cycle %0d, want none",
                         m, k, cyc_n);
            end else begin
                if (rsp_q[0].m != m || rsp_q[0].kind != k || rsp_q[0].dat !== d) begin
                    n_miss++;
                    $display("FAIL rsp: got m%0d k%0d dat %h want m%0d k%0d dat %h cycle %0d",
                             m, k, d, rsp_q[0].m, rsp_q[0].kind, rsp_q[0].dat, cyc_n);
                end
                rsp_q.delete(0);
            end
        end
    endtask

    always @(negedge clk) begin
        while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc_n) begin
            n_vec++; n_miss++;
            $display("FAIL missing_rsp: got nothing want m%0d k%0d at cycle %0d",
                     rsp_q[0].m, rsp_q[0].kind, rsp_q[0].cyc);
            rsp_q.delete(0);
        end
        while (gnt_q.size() > 0 && gnt_q[0].cyc < cyc_n) begin
            n_vec++; n_miss++;
            $display("FAIL missing_gnt: got nothing want adr %h at cycle %0d",
                     gnt_q[0].adr, gnt_q[0].cyc);
            gnt_q.delete(0);
        end
        check_rsp(0, 0, i_ack, i_dat);
        check_rsp(0, 1, i_err, i_dat);
        check_rsp(0, 2, i_rty, i_dat);
        check_rsp(1, 0, d_ack, d_dat);
        check_rsp(1, 1, d_err, d_dat);
        check_rsp(1, 2, d_rty, d_dat);
        if (w_cyc && !prev_wcyc) begin
            n_vec++;
            if (gnt_q.size() == 0 || gnt_q[0].cyc != cyc_n) begin
                n_miss++;
                $display("FAIL unexpected_gnt: got adr %h at cycle %0d want none", w_adr, cyc_n);
            end else begin
                if (w_adr !== gnt_q[0].adr || w_we !== gnt_q[0].we || w_sel !== gnt_q[0].sel) begin
                    n_miss++;
                    $display("FAIL gnt: got adr %h we %b sel %h want adr %h we %b sel %h",
                             w_adr, w_we, w_sel, gnt_q[0].adr, gnt_q[0].we, gnt_q[0].sel);
                end
                gnt_q.delete(0);
            end
        end
        prev_wcyc = w_cyc;
    end

    task automatic rand_masters();
        for (int m = 0; m < 2; m++) begin
            if (m_act[m]) begin
                if (m_stb[m] && got_err[m]) begin
                    m_act[m] = 0;
                end else if (m_stb[m] && got_ack[m]) begin
                    m_left[m]--; m_adr[m] += 4; m_dat[m] = $urandom;
                    if (m_left[m] == 0) m_act[m] = 0;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                m_act[m] = 1; m_left[m] = $urandom_range(1, 8); m_burst[m] = m_left[m] > 1;
                m_adr[m] = $urandom & 32'hffff_fffc; m_we[m] = 1'($urandom_range(0, 1));
                m_sel[m] = 4'($urandom_range(1, 15)); m_dat[m] = $urandom; m_bte[m] = 2'b00;
            end
            m_cyc[m] = m_act[m];
            m_stb[m] = m_act[m] && ($urandom_range(0, 5) != 0);
            m_cti[m] = !m_act[m] ? 3'b000 :
                       (m_left[m] == 1 ? (m_burst[m] ? 3'b111 : 3'b000) : 3'b010);
        end
    endtask

    task automatic rand_slave();
        int r;
        if (stall > 0) begin
            stall--; slv(0, 0, 0);
        end else if ($urandom_range(0, 9) == 0) begin
            stall = $urandom_range(3, 6); slv(0, 0, 0);
        end else begin
            r = $urandom_range(0, 31);
            slv(r < 14, r == 14, r == 15);
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            req(m, 0, 0, 32'h0, 0, 3'b000); m_act[m] = 0;
        end
        s_ack = 0; s_err = 0; s_rty = 0; s_dat = 32'ha5a5_5a5a;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        s_ack = 1'b1;
        check_zero("reset_outputs");
        s_ack = 1'b0;
        rst = 1'b1;
        model_reset();

        // tie after reset: data first, then instruction, then data again
        req(0, 1, 1, 32'h0000_0100, 0, 3'b000);
        req(1, 1, 1, 32'h2000_0000, 1, 3'b000);
        cycles(1, 0);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);
        check_val("tie_second_owner_adr", w_adr, 32'h0000_0100);
        cycles(1, 1);
        req(0, 0, 0, 32'h0, 0, 3'b000);
        cycles(1, 0);
        req(0, 1, 1, 32'h0000_0200, 0, 3'b000);
        req(1, 1, 1, 32'h2000_0010, 0, 3'b000);
        cycles(1, 0);
        check_val("tie_rr_data_adr", w_adr, 32'h2000_0010);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(3, 0);
        cycles(1, 1);
        req(0, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // single requester: data read, ack on the third cycle after request
        req(1, 1, 1, 32'h1000_0040, 0, 3'b000);
        cycles(1, 0);
        check_val("single_cyc", {31'd0, w_cyc}, 32'd1);
        check_val("single_adr", w_adr, 32'h1000_0040);
        cycles(2, 0);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // 8-beat instruction refill, data request arrives at beat 2
        req(0, 1, 1, 32'h0000_4000, 0, 3'b010);
        cycles(1, 0);
        for (int b = 0; b < 8; b++) begin
            if (b == 2) req(1, 1, 1, 32'h3000_0000, 1, 3'b000);
            m_adr[0] = 32'h0000_4000 + 32'(4 * b);
            m_cti[0] = (b == 7) ? 3'b111 : 3'b010;
            cycles(1, 1);
        end
        req(0, 0, 0, 32'h0, 0, 3'b000);
        cycles(1, 0);
        check_val("burst_turnaround_idle", {31'd0, w_cyc}, 32'd0);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // watchdog: slave never acks a data write; late ack in abort is dropped
        req(1, 1, 1, 32'h4000_0000, 1, 3'b000);
        cycles(5, 0);
        check_val("abort_cyc_low", {31'd0, w_cyc}, 32'd0);
        cycles(1, 0);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // ack lands exactly on the watchdog limit cycle
        req(1, 1, 1, 32'h4000_0100, 0, 3'b000);
        cycles(4, 0);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // asynchronous reset mid-burst, then a tie must go to data
        req(0, 1, 1, 32'h0000_8000, 0, 3'b010);
        cycles(1, 0);
        cycles(3, 1);
        req(1, 1, 1, 32'h5000_0000, 0, 3'b000);
        slv(1, 0, 0);
        predict();
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("async_reset_immediate");
        @(posedge clk); #1;
        model_reset();
        cyc_n++;
        check_zero("async_reset_held");
        slv(0, 0, 0);
        rst = 1'b1;
        cycles(1, 0);
        check_val("post_reset_data_first", w_adr, 32'h5000_0000);
        cycles(1, 1);
        req(1, 0, 0, 32'h0, 0, 3'b000);
        cycles(3, 0);
        cycles(1, 1);
        req(0, 0, 0, 32'h0, 0, 3'b000);
        cycles(2, 0);

        // randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rand_masters();
            rand_slave();
            step();
        end
        for (int m = 0; m < 2; m++) req(m, 0, 0, 32'h0, 0, 3'b000);
        cycles(4, 0);
        @(negedge clk); #1;
        check_val("scoreboard_drained", 32'(rsp_q.size() + gnt_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
